// File: rtl/gate_unit.sv
// Two-stage pipelined N-lane bitwise logic cell with valid/ready on both sides
// and a saturating output-toggle counter for switching-activity estimation.
module gate_unit #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 2,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  input  logic [2:0]              op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  input  logic                    cnt_clr,
  output logic [CNT_W-1:0]        toggle_cnt
);

  // Handshake: a word moves across a port on any rising edge where valid and
  // ready are both high; valid never depends on ready, ready may depend on valid.

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_NAND = 3'd1,
    OP_OR   = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_PASS = 3'd6,
    OP_ZERO = 3'd7
  } op_e;

  localparam int PC_W  = 6;
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = (SUM_W'(1) << CNT_W) - SUM_W'(1);

  logic                  s1_valid_q, s1_valid_d;
  logic [N_IN*WIDTH-1:0] s1_data_q, s1_data_d;
  logic [2:0]            s1_op_q, s1_op_d;
  logic                  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;
  logic [WIDTH-1:0]      last_out_q, last_out_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  in_xfer, out_xfer, s2_load;
  logic [WIDTH-1:0]      lane, and_r, or_r, xor_r, result;
  logic [WIDTH-1:0]      diff;
  logic [PC_W-1:0]       pc;
  logic [SUM_W-1:0]      base, sum;

  always_comb begin
    out_xfer = out_valid_q && out_ready;
    s2_load  = s1_valid_q && (!out_valid_q || out_ready);
    in_ready = !s1_valid_q || s2_load;
    in_xfer  = in_valid && in_ready;
  end

  always_comb begin
    lane  = '0;
    and_r = '1;
    or_r  = '0;
    xor_r = '0;
    for (int k = 0; k < N_IN; k++) begin
      lane  = s1_data_q[k*WIDTH +: WIDTH];
      and_r = and_r & lane;
      or_r  = or_r | lane;
      xor_r = xor_r ^ lane;
    end
    case (op_e'(s1_op_q))
      OP_AND:  result = and_r;
      OP_NAND: result = ~and_r;
      OP_OR:   result = or_r;
      OP_NOR:  result = ~or_r;
      OP_XOR:  result = xor_r;
      OP_XNOR: result = ~xor_r;
      OP_PASS: result = s1_data_q[WIDTH-1:0];
      default: result = '0;
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_op_d     = s1_op_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data;
      s1_op_d    = op;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
    if (s2_load) begin
      out_valid_d = 1'b1;
      out_data_d  = result;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  // A clear coinciding with a transfer restarts the count from that transfer.
  always_comb begin
    diff = out_data_q ^ last_out_q;
    pc   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pc = pc + PC_W'(diff[i]);
    end
    base       = cnt_clr ? '0 : SUM_W'(cnt_q);
    sum        = base + SUM_W'(pc);
    cnt_d      = cnt_q;
    last_out_d = last_out_q;
    if (out_xfer) begin
      cnt_d      = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
      last_out_d = out_data_q;
    end else if (cnt_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_op_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      last_out_q  <= '0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_op_q     <= s1_op_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      last_out_q  <= last_out_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign toggle_cnt = cnt_q;

endmodule
